spart_host_ctrl: RTL
====================

// Module: spart_host_ctrl
// PURPOSE
// - Synthesizable, parametrised SPART bus master; replaces the hand-sequenced processor-side driver.
// - Programs the baud divisor from br_cfg, then runs the iocs/iorw/ioaddr/databus protocol to the SPART.
// - Buffers host TX bytes in a queue; returns RX bytes to the host; optional echo mode loops RX into TX.
// PARAMETERS
// - CLK_HZ       100_000_000  system clock frequency; divisor = CLK_HZ/(16*baud) - 1, truncated
// - TXQ_DEPTH    4            TX queue entries, power of two, >= 2
// - CS_CYCLES    2            cycles iocs stays high per bus access, >= 1
// PORTS
// - clk          in   1   system clock
// - rst          in   1   asynchronous reset, active-high
// - br_cfg       in   2   baud select: 00=4800, 01=9600, 10=19200, 11=38400
// - echo_en      in   1   1 = each received byte is also queued for transmit
// - tx_data      in   8   host byte to transmit
// - tx_valid     in   1   host push request; accepted when tx_valid & tx_ready
// - tx_ready     out  1   TX queue not full and cfg_done
// - rx_data      out  8   received byte, valid while rx_valid
// - rx_valid     out  1   one-cycle pulse per received byte
// - rx_drop      out  1   one-cycle pulse: echo byte lost because the queue was full
// - cfg_done     out  1   divisor programmed for the current br_cfg
// - iocs         out  1   SPART chip select strobe, active-high
// - iorw         out  1   1 = read, 0 = write
// - ioaddr       out  2   00 = data, 01 = status, 10 = divisor low, 11 = divisor high
// - rda          in   1   SPART receive data available
// - tbr          in   1   SPART transmit buffer ready
// - databus      inout 8  driven only during write accesses, high-Z otherwise
// BEHAVIOUR
// - Reset values: iocs=0, iorw=1, ioaddr=00, databus=Z, tx_ready=0, rx_valid=0, rx_drop=0, cfg_done=0.
//   The queue is empty after reset; rx_data=00.
// - Bus access = 1 SETUP cycle + CS_CYCLES STROBE cycles + 1 GAP cycle.
//   - SETUP: drive ioaddr, iorw and write data with iocs=0.
//   - STROBE: hold ioaddr, iorw and write data; iocs=1.
//   - GAP: iocs=0, databus=Z.
//   - Read data is sampled on the last STROBE cycle.
// - FSM states: CFG_LO, CFG_HI, IDLE, TX_SETUP, TX_STROBE, RX_SETUP, RX_STROBE, GAP.
//   - After reset: CFG_LO writes addr 10 with div[7:0], then CFG_HI writes addr 11 with div[15:8].
//   - cfg_done rises in the GAP cycle after the CFG_HI access.
//   - IDLE with rda=1: perform an RX read at addr 00. RX has priority over TX so the SPART does not overrun.
//   - IDLE with rda=0, tbr=1 and queue not empty: pop the head entry and perform a TX write at addr 00.
//   - IDLE with tbr=0: TX waits, with no timeout.
//   - br_cfg differs from the programmed value while in IDLE: cfg_done=0, return to CFG_LO.
//     The queue contents are kept. A br_cfg change during an access is acted on only after GAP.
// - RX completion: rx_data is loaded and rx_valid pulses in the GAP cycle.
//   - With echo_en=1, the byte is pushed into the queue in the same cycle.
//   - If the queue is full, the byte is dropped and rx_drop pulses.
// - Queue rules:
//   - tx_ready is registered and equals (count<TXQ_DEPTH) & cfg_done.
//   - Host push and pop in the same cycle leave the count unchanged.
//   - Echo push and host push in the same cycle: the host push wins when only one slot is free.
//     The echo byte is dropped and rx_drop pulses.
//   - Pointers wrap modulo TXQ_DEPTH; count is $clog2(TXQ_DEPTH)+1 bits wide.
// - Divisor values at 100 MHz: 4800 -> 1301 (0x0515), 9600 -> 650 (0x028A), 19200 -> 324 (0x0144),
//   38400 -> 161 (0x00A1).
// - Reset mid-operation: all outputs return to their reset values immediately and the queue is flushed.
//   After release, configuration restarts at CFG_LO.
// - The bus-strobe sequence used by the previous testbench driver is superseded by this FSM.
// STRUCTURE
// - Package spart_pkg:
//   - address constants ADDR_DATA, ADDR_STAT, ADDR_DBL, ADDR_DBH;
//   - FSM state enum typedef;
//   - function baud_div(clk_hz, br_cfg) returning a 16-bit divisor.
// - Sub-module spart_txq: sync FIFO, DATA_W=8, DEPTH=TXQ_DEPTH, with push/pop/full/empty/count.
// - Top level holds the FSM, the strobe counter, the RX register and the tri-state databus driver.
// TESTING
// 1. rst pulse, br_cfg=01:
//    - write addr 10 data 0x8A, then write addr 11 data 0x02;
//    - each access has iocs high exactly 2 cycles; cfg_done=1 afterwards.
// 2. Push 0x6D with tbr=1:
//    - one write at addr 00 with databus=0x6D during the strobe;
//    - databus=Z in SETUP-to-IDLE gaps of read cycles and in IDLE.
// 3. tbr=0, push 4 bytes:
//    - tx_ready falls after the 4th push and no bus write occurs;
//    - raise tbr: 4 writes in FIFO order.
// 4. rda=1 with a bus model returning 0xA5 and echo_en=1:
//    - read at addr 00; rx_valid pulses with rx_data=0xA5;
//    - a subsequent write of 0xA5 occurs.
// 5. rda and tbr both high with the queue non-empty: the RX read precedes the TX write.
// 6. Assert rst during a TX_STROBE:
//    - iocs=0 and databus=Z in the same cycle; the queue is empty;
//    - reconfiguration runs after release. Then change br_cfg to 11: rewrite 0xA1/0x00.

Source files
------------

// File: rtl/spart_pkg.sv
// Shared definitions for the SPART host controller: bus addresses, FSM states
// and the baud divisor calculation.
package spart_pkg;

    localparam logic [1:0] ADDR_DATA = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DBL  = 2'b10;
    localparam logic [1:0] ADDR_DBH  = 2'b11;

    typedef enum logic [2:0] {
        CFG_LO,
        CFG_HI,
        IDLE,
        TX_SETUP,
        TX_STROBE,
        RX_SETUP,
        RX_STROBE,
        GAP
    } state_t;

    // br_cfg selects 4800 << br_cfg baud; result is truncated, then reduced by one.
    function automatic logic [15:0] baud_div(input int unsigned clk_hz, input logic [1:0] br_cfg);
        int unsigned baud;
        baud = 32'd4800 << br_cfg;
        return 16'((clk_hz / (32'd16 * baud)) - 32'd1);
    endfunction

endpackage

// File: rtl/spart_host_ctrl_if.sv
// Host-side byte interface of the SPART controller: TX push handshake and RX result.
// Handshake: a TX byte transfers on a clock edge where tx_valid & tx_ready are both high.
interface spart_host_ctrl_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_drop;

    modport master (output tx_data, tx_valid, input tx_ready, rx_data, rx_valid, rx_drop);
    modport slave  (input tx_data, tx_valid, output tx_ready, rx_data, rx_valid, rx_drop);
endinterface

// File: rtl/spart_txq.sv
// Synchronous TX FIFO with a primary push port and a secondary (echo) push port.
// When both push together the primary entry is written first; the secondary only fits if space remains.
module spart_txq #(
    parameter  int unsigned DATA_W = 8,
    parameter  int unsigned DEPTH  = 4,
    localparam int unsigned AW     = $clog2(DEPTH),
    localparam int unsigned CW     = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push2,
    input  logic [DATA_W-1:0] push2_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count,
    output logic              push2_ok
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push_ok;
    logic              pop_ok;
    logic [CW-1:0]     used_after_push;

    assign full            = (count == CW'(DEPTH));
    assign empty           = (count == '0);
    assign push_ok         = push && !full;
    assign pop_ok          = pop && !empty;
    assign used_after_push = count + CW'(push_ok);
    assign push2_ok        = push2 && (used_after_push < CW'(DEPTH));
    assign rd_data         = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push_ok) + AW'(push2_ok);
            rd_ptr <= rd_ptr + AW'(pop_ok);
            count  <= count + CW'(push_ok) + CW'(push2_ok) - CW'(pop_ok);
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok)  mem[wr_ptr] <= push_data;
        if (push2_ok) mem[wr_ptr + AW'(push_ok)] <= push2_data;
    end

endmodule

// File: rtl/spart_host_ctrl.sv
// SPART bus master: programs the baud divisor, then services RX reads (priority)
// and TX writes from the queue over the iocs/iorw/ioaddr/databus protocol.
module spart_host_ctrl
    import spart_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned TXQ_DEPTH = 4,
    parameter int unsigned CS_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         br_cfg,
    input  logic               echo_en,
    spart_host_ctrl_if.slave   host,
    output logic               cfg_done,
    output logic               iocs,
    output logic               iorw,
    output logic [1:0]         ioaddr,
    input  logic               rda,
    input  logic               tbr,
    inout  wire  [7:0]         databus,
    output state_t             dbg_state
);

    localparam int unsigned    CNT_W    = $clog2(CS_CYCLES + 2);
    localparam int unsigned    QCW      = $clog2(TXQ_DEPTH) + 1;
    localparam logic [CNT_W-1:0] CFG_LAST = CNT_W'(CS_CYCLES + 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(CS_CYCLES - 1);
    localparam logic [15:0]    DIV0     = baud_div(CLK_HZ, 2'd0);
    localparam logic [15:0]    DIV1     = baud_div(CLK_HZ, 2'd1);
    localparam logic [15:0]    DIV2     = baud_div(CLK_HZ, 2'd2);
    localparam logic [15:0]    DIV3     = baud_div(CLK_HZ, 2'd3);

    state_t           state, state_nxt, prev_acc;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       prog_cfg;
    logic             cfg_done_nxt;
    logic             tx_ready_r;
    logic [7:0]       tx_byte;
    logic [7:0]       rx_data_r;
    logic [15:0]      div;
    logic             bus_oe;
    logic [7:0]       bus_wdata;
    logic             pop;
    logic             host_push;
    logic             echo_push;
    logic             echo_ok;
    logic             rx_done;
    logic [7:0]       q_rd_data;
    logic             q_full;
    logic             q_empty;
    logic [QCW-1:0]   q_count;
    logic [QCW-1:0]   q_count_nxt;

    always_comb begin
        case (prog_cfg)
            2'd0:    div = DIV0;
            2'd1:    div = DIV1;
            2'd2:    div = DIV2;
            default: div = DIV3;
        endcase
    end

    assign rx_done     = (state == GAP) && (prev_acc == RX_STROBE);
    assign echo_push   = rx_done && echo_en;
    assign host_push   = host.tx_valid && tx_ready_r && !q_full;
    assign q_count_nxt = q_count + QCW'(host_push) + QCW'(echo_ok) - QCW'(pop);

    assign host.tx_ready = tx_ready_r;
    assign host.rx_data  = rx_data_r;
    assign host.rx_valid = rx_done;
    assign host.rx_drop  = echo_push && !echo_ok;
    assign databus       = bus_oe ? bus_wdata : 8'hzz;
    assign dbg_state     = state;

    spart_txq #(.DATA_W(8), .DEPTH(TXQ_DEPTH)) u_txq (
        .clk        (clk),
        .rst        (rst),
        .push       (host_push),
        .push_data  (host.tx_data),
        .push2      (echo_push),
        .push2_data (rx_data_r),
        .pop        (pop),
        .rd_data    (q_rd_data),
        .full       (q_full),
        .empty      (q_empty),
        .count      (q_count),
        .push2_ok   (echo_ok)
    );

    // Config states spend cnt=0 idle (reset-safe bus values), cnt=1 in setup, then strobe.
    always_comb begin
        state_nxt    = state;
        cfg_done_nxt = cfg_done;
        pop          = 1'b0;
        bus_oe       = 1'b0;
        bus_wdata    = 8'h00;
        iocs         = 1'b0;
        iorw         = 1'b1;
        ioaddr       = ADDR_DATA;
        case (state)
            CFG_LO, CFG_HI: begin
                if (cnt != '0) begin
                    bus_oe    = 1'b1;
                    iorw      = 1'b0;
                    ioaddr    = (state == CFG_LO) ? ADDR_DBL : ADDR_DBH;
                    bus_wdata = (state == CFG_LO) ? div[7:0] : div[15:8];
                    iocs      = (cnt >= CNT_W'(2));
                end
                if (cnt == CFG_LAST) begin
                    state_nxt = GAP;
                    if (state == CFG_HI) cfg_done_nxt = 1'b1;
                end
            end
            IDLE: begin
                if (br_cfg != prog_cfg) begin
                    state_nxt    = CFG_LO;
                    cfg_done_nxt = 1'b0;
                end else if (rda) begin
                    state_nxt = RX_SETUP;
                end else if (tbr && !q_empty) begin
                    state_nxt = TX_SETUP;
                    pop       = 1'b1;
                end
            end
            TX_SETUP, TX_STROBE: begin
                bus_oe    = 1'b1;
                iorw      = 1'b0;
                bus_wdata = tx_byte;
                iocs      = (state == TX_STROBE);
                if (state == TX_SETUP)    state_nxt = TX_STROBE;
                else if (cnt == STB_LAST) state_nxt = GAP;
            end
            RX_SETUP: state_nxt = RX_STROBE;
            RX_STROBE: begin
                iocs = 1'b1;
                if (cnt == STB_LAST) state_nxt = GAP;
            end
            GAP: state_nxt = (prev_acc == CFG_LO) ? CFG_HI : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= CFG_LO;
            cnt        <= '0;
            prev_acc   <= CFG_LO;
            prog_cfg   <= 2'b00;
            cfg_done   <= 1'b0;
            tx_ready_r <= 1'b0;
            tx_byte    <= 8'h00;
            rx_data_r  <= 8'h00;
        end else begin
            state      <= state_nxt;
            cnt        <= (state_nxt == state) ? cnt + CNT_W'(1) : '0;
            cfg_done   <= cfg_done_nxt;
            tx_ready_r <= (q_count_nxt < QCW'(TXQ_DEPTH)) && cfg_done_nxt;
            if (state_nxt == GAP && state != GAP) prev_acc <= state;
            if (state == CFG_LO && cnt == '0)     prog_cfg <= br_cfg;
            if (pop)                              tx_byte  <= q_rd_data;
            if (state == RX_STROBE && cnt == STB_LAST) rx_data_r <= databus;
        end
    end

endmodule
